// File: rtl/sht40_meas_scheduler_pkg.sv
// Shared definitions for the SHT40 measurement scheduler.
// Holds the FSM state enum, the sensor I2C address, the four command
// codes, the CRC-8 constants and the Cmd_Sel -> command byte mapping.
package sht40_meas_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_START,
    ST_WR_WAIT,
    ST_MEAS_WAIT,
    ST_RD_START,
    ST_RD_COLLECT,
    ST_CHECK,
    ST_BACKOFF
  } state_e;

  localparam logic [6:0] SHT40_ADDR     = 7'h44;

  localparam logic [7:0] CMD_MEAS_HIGH  = 8'hFD;
  localparam logic [7:0] CMD_MEAS_MED   = 8'hF6;
  localparam logic [7:0] CMD_MEAS_LOW   = 8'hE0;
  localparam logic [7:0] CMD_SOFT_RESET = 8'h94;

  localparam logic [7:0] CRC_POLY       = 8'h31;
  localparam logic [7:0] CRC_INIT       = 8'hFF;

  function automatic logic [7:0] cmd_code(input logic [1:0] sel);
    logic [7:0] code;
    case (sel)
      2'b00:   code = CMD_MEAS_HIGH;
      2'b01:   code = CMD_MEAS_MED;
      2'b10:   code = CMD_MEAS_LOW;
      default: code = CMD_SOFT_RESET;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/sht40_meas_scheduler_crc8.sv
// Combinational SHT40 CRC-8 over one 16-bit data word.
// Polynomial 0x31, init 0xFF, MSB first, no reflection, no final XOR.
// Ports:
//   data_i  16-bit word (first transmitted byte in [15:8])
//   crc_o   8-bit CRC of data_i
module sht40_crc8
  import sht40_meas_scheduler_pkg::*;
(
  input  logic [15:0] data_i,
  output logic [7:0]  crc_o
);

  logic [7:0] crc_v;

  // Bit-serial form: feedback is the outgoing CRC MSB XOR the next data bit.
  always_comb begin
    crc_v = CRC_INIT;
    for (int i = 15; i >= 0; i--) begin
      if (crc_v[7] ^ data_i[i]) crc_v = {crc_v[6:0], 1'b0} ^ CRC_POLY;
      else                      crc_v = {crc_v[6:0], 1'b0};
    end
    crc_o = crc_v;
  end

endmodule

// File: rtl/sht40_meas_scheduler.sv
// SHT40 measurement scheduler: sequences command write, conversion wait,
// 6-byte read and CRC check through an external I2C master, with periodic
// or single-shot triggering, bounded retries and sticky error flags.
// Handshake: Processor_Ready is a one-cycle start strobe to the master with
// I2c_Writes/Command_Data_Frames held until the matching Master_Done pulse;
// Master_Nack is only meaningful in the Master_Done cycle; each Rx_Valid
// pulse carries one byte.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   Enable, Single_Shot   periodic mode / one-shot request
//   Cmd_Sel               command select (latched at measurement start)
//   Master_Done/Nack      transaction completion from the I2C master
//   Rx_Valid/Rx_Byte      received byte stream
//   Processor_Ready, I2c_Writes, Peripheral_Address, Command_Data_Frames
//                         transaction request to the master
//   Temperature_Output, Humidity_Output, Meas_Valid   measurement results
//   CRC_Error_Out, Nack_Error_Out                     sticky give-up flags
//   Busy                  high whenever the FSM is not idle
module sht40_meas_scheduler
  import sht40_meas_scheduler_pkg::*;
#(
  parameter int PERIOD_CYCLES    = 1000000,
  parameter int MEAS_WAIT_CYCLES = 100000,
  parameter int MAX_RETRY        = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Enable,
  input  logic        Single_Shot,
  input  logic [1:0]  Cmd_Sel,
  input  logic        Master_Done,
  input  logic        Master_Nack,
  input  logic        Rx_Valid,
  input  logic [7:0]  Rx_Byte,
  output logic        Processor_Ready,
  output logic        I2c_Writes,
  output logic [6:0]  Peripheral_Address,
  output logic [7:0]  Command_Data_Frames,
  output logic [15:0] Temperature_Output,
  output logic [15:0] Humidity_Output,
  output logic        Meas_Valid,
  output logic        CRC_Error_Out,
  output logic        Nack_Error_Out,
  output logic        Busy
);

  localparam logic [31:0] PERIOD_LAST = 32'(PERIOD_CYCLES - 1);
  localparam logic [31:0] WAIT_LAST   = 32'(MEAS_WAIT_CYCLES - 1);
  localparam logic [7:0]  RETRY_LIMIT = 8'(MAX_RETRY);

  state_e      state_q, state_d;
  logic [31:0] period_q, period_d;
  logic        pend_q, pend_d;
  logic [31:0] wait_q, wait_d;
  logic [7:0]  retry_q, retry_d;
  logic        err_crc_q, err_crc_d;   // 1: last failure was CRC, 0: NACK/short read
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  rx_q [6];
  logic [7:0]  rx_d [6];
  logic [7:0]  cmd_q, cmd_d;
  logic [15:0] temp_q, temp_d, hum_q, hum_d;
  logic        meas_valid_q, meas_valid_d;
  logic        crc_err_q, crc_err_d, nack_err_q, nack_err_d;

  logic        expiry;
  logic        crc_ok;
  logic [7:0]  crc_t, crc_h;

  sht40_crc8 u_crc_t (.data_i({rx_q[0], rx_q[1]}), .crc_o(crc_t));
  sht40_crc8 u_crc_h (.data_i({rx_q[3], rx_q[4]}), .crc_o(crc_h));

  assign crc_ok = (crc_t == rx_q[2]) && (crc_h == rx_q[5]);
  assign expiry = Enable && (period_q == 32'd0);

  always_comb begin
    state_d      = state_q;
    period_d     = period_q;
    pend_d       = pend_q;
    wait_d       = wait_q;
    retry_d      = retry_q;
    err_crc_d    = err_crc_q;
    idx_d        = idx_q;
    rx_d         = rx_q;
    cmd_d        = cmd_q;
    temp_d       = temp_q;
    hum_d        = hum_q;
    meas_valid_d = 1'b0;
    crc_err_d    = crc_err_q;
    nack_err_d   = nack_err_q;

    // Period counter free-runs only in periodic mode; an expiry seen while
    // busy is remembered in pend_q and serviced once back in IDLE.
    if (!Enable) begin
      period_d = PERIOD_LAST;
      pend_d   = 1'b0;
    end else begin
      period_d = expiry ? PERIOD_LAST : period_q - 32'd1;
      pend_d   = pend_q | expiry;
    end

    case (state_q)
      ST_IDLE: begin
        if (Single_Shot || expiry || pend_q) begin
          state_d = ST_WR_START;
          pend_d  = 1'b0;
          cmd_d   = cmd_code(Cmd_Sel);
          retry_d = 8'd0;
        end
      end
      ST_WR_START: state_d = ST_WR_WAIT;
      ST_WR_WAIT: begin
        if (Master_Done) begin
          wait_d = 32'd0;
          if (Master_Nack) begin
            err_crc_d = 1'b0;
            state_d   = ST_BACKOFF;
          end else if (cmd_q == CMD_SOFT_RESET) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_MEAS_WAIT;
          end
        end
      end
      ST_MEAS_WAIT: begin
        if (wait_q == WAIT_LAST) state_d = ST_RD_START;
        else                     wait_d  = wait_q + 32'd1;
      end
      ST_RD_START: begin
        idx_d   = 3'd0;
        state_d = ST_RD_COLLECT;
      end
      ST_RD_COLLECT: begin
        if (Rx_Valid && (idx_q < 3'd6)) begin
          rx_d[idx_q] = Rx_Byte;
          idx_d       = idx_q + 3'd1;
        end
        // idx_d already includes a byte arriving in the Master_Done cycle.
        if (Master_Done) begin
          if (Master_Nack || (idx_d != 3'd6)) begin
            err_crc_d = 1'b0;
            wait_d    = 32'd0;
            state_d   = ST_BACKOFF;
          end else begin
            state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (crc_ok) begin
          temp_d       = {rx_q[0], rx_q[1]};
          hum_d        = {rx_q[3], rx_q[4]};
          meas_valid_d = 1'b1;
          retry_d      = 8'd0;
          crc_err_d    = 1'b0;
          nack_err_d   = 1'b0;
          state_d      = ST_IDLE;
        end else begin
          err_crc_d = 1'b1;
          wait_d    = 32'd0;
          state_d   = ST_BACKOFF;
        end
      end
      ST_BACKOFF: begin
        if (retry_q == RETRY_LIMIT) begin
          if (err_crc_q) crc_err_d  = 1'b1;
          else           nack_err_d = 1'b1;
          state_d = ST_IDLE;
        end else if (wait_q == WAIT_LAST) begin
          retry_d = retry_q + 8'd1;
          state_d = ST_WR_START;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      period_q     <= PERIOD_LAST;
      pend_q       <= 1'b0;
      wait_q       <= 32'd0;
      retry_q      <= 8'd0;
      err_crc_q    <= 1'b0;
      idx_q        <= 3'd0;
      for (int i = 0; i < 6; i++) rx_q[i] <= 8'd0;
      cmd_q        <= CMD_MEAS_HIGH;
      temp_q       <= 16'd0;
      hum_q        <= 16'd0;
      meas_valid_q <= 1'b0;
      crc_err_q    <= 1'b0;
      nack_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_q     <= period_d;
      pend_q       <= pend_d;
      wait_q       <= wait_d;
      retry_q      <= retry_d;
      err_crc_q    <= err_crc_d;
      idx_q        <= idx_d;
      rx_q         <= rx_d;
      cmd_q        <= cmd_d;
      temp_q       <= temp_d;
      hum_q        <= hum_d;
      meas_valid_q <= meas_valid_d;
      crc_err_q    <= crc_err_d;
      nack_err_q   <= nack_err_d;
    end
  end

  assign Processor_Ready     = (state_q == ST_WR_START) || (state_q == ST_RD_START);
  assign I2c_Writes          = (state_q == ST_WR_START) || (state_q == ST_WR_WAIT);
  assign Peripheral_Address  = SHT40_ADDR;
  assign Command_Data_Frames = cmd_q;
  assign Temperature_Output  = temp_q;
  assign Humidity_Output     = hum_q;
  assign Meas_Valid          = meas_valid_q;
  assign CRC_Error_Out       = crc_err_q;
  assign Nack_Error_Out      = nack_err_q;
  assign Busy                = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sht40_meas_scheduler.sv
module tb_sht40_meas_scheduler;

  localparam int PERIOD = 200;
  localparam int MWAIT  = 20;
  localparam int MRETRY = 3;
  localparam int TMO    = 400;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        single_shot = 1'b0;
  logic [1:0]  cmd_sel = 2'b00;
  logic        master_done = 1'b0;
  logic        master_nack = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte = 8'h00;

  logic        Processor_Ready, I2c_Writes, Meas_Valid;
  logic        CRC_Error_Out, Nack_Error_Out, Busy;
  logic [6:0]  Peripheral_Address;
  logic [7:0]  Command_Data_Frames;
  logic [15:0] Temperature_Output, Humidity_Output;

  logic [15:0] crc_in = 16'h0000;
  logic [7:0]  crc_out;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sht40_meas_scheduler #(
    .PERIOD_CYCLES(PERIOD), .MEAS_WAIT_CYCLES(MWAIT), .MAX_RETRY(MRETRY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .Enable(enable), .Single_Shot(single_shot),
    .Cmd_Sel(cmd_sel), .Master_Done(master_done), .Master_Nack(master_nack),
    .Rx_Valid(rx_valid), .Rx_Byte(rx_byte),
    .Processor_Ready(Processor_Ready), .I2c_Writes(I2c_Writes),
    .Peripheral_Address(Peripheral_Address), .Command_Data_Frames(Command_Data_Frames),
    .Temperature_Output(Temperature_Output), .Humidity_Output(Humidity_Output),
    .Meas_Valid(Meas_Valid), .CRC_Error_Out(CRC_Error_Out),
    .Nack_Error_Out(Nack_Error_Out), .Busy(Busy)
  );

  sht40_crc8 u_crc (.data_i(crc_in), .crc_o(crc_out));

  // ---------------- reference model / scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_temp = 16'h0000;
  logic [15:0] exp_hum  = 16'h0000;
  logic [7:0]  exp_q[$];

  // CRC as polynomial remainder: (word XOR init-aligned) * x^8 mod 0x131.
  function automatic logic [7:0] crc_ref(input logic [15:0] d);
    logic [23:0] r;
    r = {d ^ 16'hFF00, 8'h00};
    for (int i = 23; i >= 8; i--) if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h131;
    return r[7:0];
  endfunction

  function automatic logic [7:0] cmd_of(input logic [1:0] sel);
    case (sel)
      2'b00:   return 8'hFD;
      2'b01:   return 8'hF6;
      2'b10:   return 8'hE0;
      default: return 8'h94;
    endcase
  endfunction

  function automatic logic [47:0] make_frame(input logic [15:0] t, input logic [15:0] h);
    return {t, crc_ref(t), h, crc_ref(h)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_single_shot();
    single_shot = 1'b1;
    step();
    single_shot = 1'b0;
  endtask

  task automatic wait_pr(output bit got, output logic wr, output logic [7:0] cmd, output int waited);
    waited = 0;
    while (Processor_Ready !== 1'b1 && waited < TMO) begin
      step();
      waited++;
    end
    got = (Processor_Ready === 1'b1);
    wr  = I2c_Writes;
    cmd = Command_Data_Frames;
  endtask

  task automatic master_write(input logic nack, output logic pr_after);
    step();
    pr_after = Processor_Ready;
    repeat ($urandom_range(0, 4)) step();
    master_done = 1'b1; master_nack = nack;
    step();
    master_done = 1'b0; master_nack = 1'b0;
  endtask

  task automatic master_read(input logic [47:0] data, input logic [7:0] extra,
                             input int nbytes, input logic nack, output logic pr_after);
    step();
    pr_after = Processor_Ready;
    for (int k = 0; k < nbytes; k++) begin
      repeat ($urandom_range(0, 2)) step();
      rx_valid = 1'b1;
      if (k < 6) rx_byte = data[47 - 8*k -: 8];
      else       rx_byte = extra;
      step();
      rx_valid = 1'b0;
    end
    repeat ($urandom_range(0, 2)) step();
    master_done = 1'b1; master_nack = nack;
    step();
    master_done = 1'b0; master_nack = 1'b0;
  endtask

  task automatic watch(input int n, output int pulses, output int first_at, output int extra_pr);
    pulses = 0; first_at = 0; extra_pr = 0;
    for (int i = 1; i <= n; i++) begin
      step();
      if (Meas_Valid === 1'b1) begin
        pulses++;
        if (first_at == 0) first_at = i;
      end
      if (Processor_Ready === 1'b1) extra_pr++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    n_tests++;
    if (Processor_Ready !== 1'b0 || I2c_Writes !== 1'b0 || Meas_Valid !== 1'b0 || Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: ready=%b writes=%b valid=%b busy=%b, expected all 0",
               Processor_Ready, I2c_Writes, Meas_Valid, Busy);
    end
    n_tests++;
    if (Peripheral_Address !== 7'h44 || Command_Data_Frames !== 8'hFD) begin
      n_fail++;
      $display("FAIL reset_addr_cmd: addr=%02h cmd=%02h, expected 44 fd", Peripheral_Address, Command_Data_Frames);
    end
    n_tests++;
    if (Temperature_Output !== 16'h0 || Humidity_Output !== 16'h0 || CRC_Error_Out !== 1'b0 || Nack_Error_Out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_data: t=%04h h=%04h crc_err=%b nack_err=%b, expected 0", Temperature_Output,
               Humidity_Output, CRC_Error_Out, Nack_Error_Out);
    end
  endtask

  task automatic test_crc_unit();
    logic [15:0] v;
    crc_in = 16'hBEEF; #1;
    n_tests++;
    if (crc_out !== 8'h92) begin n_fail++; $display("FAIL crc_beef: got %02h, expected 92", crc_out); end
    crc_in = 16'h6666; #1;
    n_tests++;
    if (crc_out !== 8'h93) begin n_fail++; $display("FAIL crc_6666: got %02h, expected 93", crc_out); end
    for (int i = 0; i < 8; i++) begin
      v = 16'($urandom());
      crc_in = v; #1;
      n_tests++;
      if (crc_out !== crc_ref(v)) begin
        n_fail++;
        $display("FAIL crc_rand: in=%04h got %02h, expected %02h", v, crc_out, crc_ref(v));
      end
    end
  endtask

  task automatic test_single_shot();
    bit got; logic wr; logic [7:0] cmd; int waited; logic pra;
    int pulses, first_at, xpr;
    cmd_sel = 2'b00;
    pulse_single_shot();
    wait_pr(got, wr, cmd, waited);
    n_tests++;
    if (got !== 1'b1 || wr !== 1'b1 || cmd !== 8'hFD || Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ss_write: got=%0b writes=%b cmd=%02h busy=%b, expected 1 1 fd 1", got, wr, cmd, Busy);
    end
    master_write(1'b0, pra);
    n_tests++;
    if (pra !== 1'b0) begin n_fail++; $display("FAIL ss_ready_width: ready=%b one cycle after start, expected 0", pra); end
    wait_pr(got, wr, cmd, waited);
    n_tests++;
    if (got !== 1'b1 || wr !== 1'b0) begin
      n_fail++; $display("FAIL ss_read: got=%0b writes=%b, expected 1 0", got, wr);
    end
    n_tests++;
    if (waited != MWAIT) begin
      n_fail++; $display("FAIL ss_meas_wait: read started %0d cycles after write done, expected %0d", waited, MWAIT);
    end
    master_read(48'h6666_93_6666_93, 8'h00, 6, 1'b0, pra);
    watch(6, pulses, first_at, xpr);
    exp_temp = 16'h6666; exp_hum = 16'h6666;
    n_tests++;
    if (pulses != 1 || first_at == 0 || first_at > 3) begin
      n_fail++; $display("FAIL ss_meas_valid: pulses=%0d first_at=%0d, expected 1 within 3", pulses, first_at);
    end
    n_tests++;
    if (Temperature_Output !== exp_temp || Humidity_Output !== exp_hum) begin
      n_fail++; $display("FAIL ss_outputs: t=%04h h=%04h, expected %04h %04h", Temperature_Output,
                         Humidity_Output, exp_temp, exp_hum);
    end
    n_tests++;
    if (Busy !== 1'b0 || xpr != 0) begin
      n_fail++; $display("FAIL ss_idle: busy=%b extra_ready=%0d, expected 0 0", Busy, xpr);
    end
  endtask

  task automatic test_random_measurements();
    bit got; logic wr; logic [7:0] cmd; int waited; logic pra;
    int pulses, first_at, xpr;
    logic [1:0] sel; logic [15:0] t, h; logic [7:0] exp_cmd;
    for (int n = 0; n < 6; n++) begin
      sel = 2'($urandom_range(0, 2));
      cmd_sel = sel;
      exp_q.push_back(cmd_of(sel));
      pulse_single_shot();
      cmd_sel = 2'($urandom_range(0, 3));
      wait_pr(got, wr, cmd, waited);
      exp_cmd = exp_q.pop_front();
      n_tests++;
      if (got !== 1'b1 || wr !== 1'b1 || cmd !== exp_cmd) begin
        n_fail++; $display("FAIL rand_write[%0d]: got=%0b writes=%b cmd=%02h, expected 1 1 %02h", n, got, wr, cmd, exp_cmd);
      end
      master_write(1'b0, pra);
      cmd_sel = 2'($urandom_range(0, 3));
      wait_pr(got, wr, cmd, waited);
      n_tests++;
      if (got !== 1'b1 || wr !== 1'b0 || cmd !== exp_cmd) begin
        n_fail++; $display("FAIL rand_read[%0d]: got=%0b writes=%b cmd=%02h, expected 1 0 %02h", n, got, wr, cmd, exp_cmd);
      end
      t = 16'($urandom()); h = 16'($urandom());
      // One pass sends a seventh byte, which must be ignored.
      master_read(make_frame(t, h), 8'($urandom()), (n == 3) ? 7 : 6, 1'b0, pra);
      watch(4, pulses, first_at, xpr);
      exp_temp = t; exp_hum = h;
      n_tests++;
      if (pulses != 1 || Temperature_Output !== exp_temp || Humidity_Output !== exp_hum) begin
        n_fail++; $display("FAIL rand_result[%0d]: pulses=%0d t=%04h h=%04h, expected 1 %04h %04h", n, pulses,
                           Temperature_Output, Humidity_Output, exp_temp, exp_hum);
      end
    end
  endtask

  task automatic test_crc_retry();
    bit got; logic wr; logic [7:0] cmd; int waited; logic pra;
    int pulses, first_at, xpr, reads;
    logic [47:0] frame;
    reads = 0;
    frame = make_frame(16'h1234, 16'hABCD);
    frame[31:24] = frame[31:24] ^ 8'h5A;   // corrupt byte 2
    cmd_sel = 2'b00;
    pulse_single_shot();
    for (int a = 0; a < 4; a++) begin
      wait_pr(got, wr, cmd, waited);
      if (got !== 1'b1 || wr !== 1'b1) break;
      master_write(1'b0, pra);
      if (a == 1) pulse_single_shot();   // ignored while busy
      wait_pr(got, wr, cmd, waited);
      if (got !== 1'b1 || wr !== 1'b0) break;
      reads++;
      master_read(frame, 8'h00, 6, 1'b0, pra);
    end
    watch(3 * MWAIT, pulses, first_at, xpr);
    n_tests++;
    if (reads != MRETRY + 1 || xpr != 0) begin
      n_fail++; $display("FAIL crcretry_reads: reads=%0d further_starts=%0d, expected %0d 0", reads, xpr, MRETRY + 1);
    end
    n_tests++;
    if (CRC_Error_Out !== 1'b1 || Nack_Error_Out !== 1'b0 || Busy !== 1'b0 || pulses != 0) begin
      n_fail++; $display("FAIL crcretry_flags: crc_err=%b nack_err=%b busy=%b valid_pulses=%0d, expected 1 0 0 0",
                         CRC_Error_Out, Nack_Error_Out, Busy, pulses);
    end
    n_tests++;
    if (Temperature_Output !== exp_temp || Humidity_Output !== exp_hum) begin
      n_fail++; $display("FAIL crcretry_hold: t=%04h h=%04h, expected %04h %04h", Temperature_Output,
                         Humidity_Output, exp_temp, exp_hum);
    end
  endtask

  task automatic test_nack_then_good();
    bit got; logic wr; logic [7:0] cmd; int waited; logic pra;
    int pulses, first_at, xpr;
    logic [15:0] t, h;
    cmd_sel = 2'b01;
    pulse_single_shot();
    wait_pr(got, wr, cmd, waited);
    master_write(1'b1, pra);
    wait_pr(got, wr, cmd, waited);
    n_tests++;
    if (got !== 1'b1 || wr !== 1'b1 || cmd !== 8'hF6 || waited != MWAIT) begin
      n_fail++; $display("FAIL nack_retry: got=%0b writes=%b cmd=%02h backoff=%0d, expected 1 1 f6 %0d",
                         got, wr, cmd, waited, MWAIT);
    end
    master_write(1'b0, pra);
    wait_pr(got, wr, cmd, waited);
    t = 16'($urandom()); h = 16'($urandom());
    master_read(make_frame(t, h), 8'h00, 6, 1'b0, pra);
    watch(4, pulses, first_at, xpr);
    exp_temp = t; exp_hum = h;
    n_tests++;
    if (pulses != 1 || Temperature_Output !== exp_temp || Humidity_Output !== exp_hum) begin
      n_fail++; $display("FAIL nack_good: pulses=%0d t=%04h h=%04h, expected 1 %04h %04h", pulses,
                         Temperature_Output, Humidity_Output, exp_temp, exp_hum);
    end
    n_tests++;
    if (Nack_Error_Out !== 1'b0 || CRC_Error_Out !== 1'b0) begin
      n_fail++; $display("FAIL nack_sticky: nack_err=%b crc_err=%b, expected 0 0 after success",
                         Nack_Error_Out, CRC_Error_Out);
    end
  endtask

  task automatic test_nack_exhaust();
    bit got; logic wr; logic [7:0] cmd; int waited; logic pra;
    int pulses, first_at, xpr, writes;
    writes = 0;
    cmd_sel = 2'b10;
    pulse_single_shot();
    for (int a = 0; a < 4; a++) begin
      wait_pr(got, wr, cmd, waited);
      if (got !== 1'b1 || wr !== 1'b1) break;
      writes++;
      master_write(1'b1, pra);
    end
    watch(3 * MWAIT, pulses, first_at, xpr);
    n_tests++;
    if (writes != MRETRY + 1 || xpr != 0) begin
      n_fail++; $display("FAIL nackx_writes: writes=%0d further_starts=%0d, expected %0d 0", writes, xpr, MRETRY + 1);
    end
    n_tests++;
    if (Nack_Error_Out !== 1'b1 || CRC_Error_Out !== 1'b0 || Busy !== 1'b0 ||
        Temperature_Output !== exp_temp || Humidity_Output !== exp_hum) begin
      n_fail++; $display("FAIL nackx_flags: nack_err=%b crc_err=%b busy=%b t=%04h h=%04h, expected 1 0 0 %04h %04h",
                         Nack_Error_Out, CRC_Error_Out, Busy, Temperature_Output, Humidity_Output, exp_temp, exp_hum);
    end
  endtask

  task automatic test_reset_mid();
    bit got; logic wr; logic [7:0] cmd; int waited; logic pra;
    int pulses, first_at, xpr;
    logic [15:0] t, h;
    cmd_sel = 2'b00;
    pulse_single_shot();
    wait_pr(got, wr, cmd, waited);
    master_write(1'b0, pra);
    wait_pr(got, wr, cmd, waited);
    step();
    for (int k = 0; k < 3; k++) begin
      rx_valid = 1'b1; rx_byte = 8'($urandom()); step(); rx_valid = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    exp_temp = 16'h0; exp_hum = 16'h0;
    n_tests++;
    if (Busy !== 1'b0 || Processor_Ready !== 1'b0 || Nack_Error_Out !== 1'b0 || Command_Data_Frames !== 8'hFD) begin
      n_fail++; $display("FAIL rstmid_async: busy=%b ready=%b nack_err=%b cmd=%02h, expected 0 0 0 fd",
                         Busy, Processor_Ready, Nack_Error_Out, Command_Data_Frames);
    end
    step();
    n_tests++;
    if (Busy !== 1'b0 || Temperature_Output !== exp_temp || Humidity_Output !== exp_hum || Peripheral_Address !== 7'h44) begin
      n_fail++; $display("FAIL rstmid_values: busy=%b t=%04h h=%04h addr=%02h, expected 0 0000 0000 44",
                         Busy, Temperature_Output, Humidity_Output, Peripheral_Address);
    end
    rst_n = 1'b1;
    step();
    cmd_sel = 2'b10;
    pulse_single_shot();
    wait_pr(got, wr, cmd, waited);
    n_tests++;
    if (got !== 1'b1 || wr !== 1'b1 || cmd !== 8'hE0) begin
      n_fail++; $display("FAIL rstmid_restart: got=%0b writes=%b cmd=%02h, expected 1 1 e0", got, wr, cmd);
    end
    master_write(1'b0, pra);
    wait_pr(got, wr, cmd, waited);
    t = 16'($urandom()); h = 16'($urandom());
    master_read(make_frame(t, h), 8'h00, 6, 1'b0, pra);
    watch(4, pulses, first_at, xpr);
    exp_temp = t; exp_hum = h;
    n_tests++;
    if (pulses != 1 || Temperature_Output !== exp_temp || Humidity_Output !== exp_hum) begin
      n_fail++; $display("FAIL rstmid_result: pulses=%0d t=%04h h=%04h, expected 1 %04h %04h", pulses,
                         Temperature_Output, Humidity_Output, exp_temp, exp_hum);
    end
  endtask

  task automatic test_periodic();
    bit got; logic wr; logic [7:0] cmd; int waited; logic pra;
    int starts [4];
    cmd_sel = 2'b11;
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_pr(got, wr, cmd, waited);
      starts[i] = cyc;
      n_tests++;
      if (got !== 1'b1 || wr !== 1'b1 || cmd !== 8'h94) begin
        n_fail++; $display("FAIL periodic_start[%0d]: got=%0b writes=%b cmd=%02h, expected 1 1 94", i, got, wr, cmd);
      end
      master_write(1'b0, pra);
    end
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (starts[i+1] - starts[i] != PERIOD) begin
        n_fail++; $display("FAIL periodic_spacing[%0d]: %0d cycles, expected %0d", i, starts[i+1] - starts[i], PERIOD);
      end
    end
    step();
    n_tests++;
    if (Busy !== 1'b0) begin n_fail++; $display("FAIL periodic_idle: busy=%b, expected 0", Busy); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_crc_unit();
    test_single_shot();
    test_random_measurements();
    test_crc_retry();
    test_nack_then_good();
    test_nack_exhaust();
    test_reset_mid();
    test_periodic();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sht40_meas_scheduler.md
SHT40_MEAS_SCHEDULER -- requirements
Module: sht40_meas_scheduler

Interface
REQ-001 SHALL have parameter PERIOD_CYCLES, default 1000000, clk cycles between periodic measurement starts.
REQ-002 SHALL have parameter MEAS_WAIT_CYCLES, default 100000, clk cycles between command-write completion and read start.
REQ-003 SHALL have parameter MAX_RETRY, default 3, retries after NACK or CRC error before giving up.
REQ-004 SHALL have ports as listed below; one clock, clk; reset rst_n is asynchronous, active-low.
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- Enable  in  1  periodic measurement mode
- Single_Shot  in  1  one-cycle request for one measurement
- Cmd_Sel  in  2  00=0xFD, 01=0xF6, 10=0xE0, 11=0x94 (soft reset, no read)
- Master_Done  in  1  one-cycle pulse: I2C transaction finished
- Master_Nack  in  1  valid with Master_Done: transaction NACKed
- Rx_Valid  in  1  one-cycle pulse: Rx_Byte valid
- Rx_Byte  in  8  received byte
- Processor_Ready  out  1  one-cycle transaction start to master
- I2c_Writes  out  1  1=write, 0=read; stable from start until Master_Done
- Peripheral_Address  out  7  constant 0x44
- Command_Data_Frames  out  8  command byte for the write
- Temperature_Output  out  16  last good temperature word
- Humidity_Output  out  16  last good RH word
- Meas_Valid  out  1  one-cycle pulse: new outputs latched
- CRC_Error_Out  out  1  sticky: retries exhausted on CRC error
- Nack_Error_Out  out  1  sticky: retries exhausted on NACK
- Busy  out  1  high in any state except IDLE

Function
REQ-005 SHALL implement states IDLE, WR_START, WR_WAIT, MEAS_WAIT, RD_START, RD_COLLECT, CHECK, BACKOFF.
REQ-006 SHALL leave IDLE for WR_START on Single_Shot, or on period-counter expiry while Enable=1; Single_Shot while Busy is ignored.
REQ-007 SHALL free-run the period counter while Enable=1 and reload it to PERIOD_CYCLES-1 on expiry; a pending expiry during Busy is held and serviced on return to IDLE.
REQ-008 SHALL latch Cmd_Sel into Command_Data_Frames at the IDLE exit; later Cmd_Sel changes do not affect the in-flight measurement.
REQ-009 SHALL pulse Processor_Ready exactly one cycle in WR_START (I2c_Writes=1) and in RD_START (I2c_Writes=0), then enter WR_WAIT/RD_COLLECT.
REQ-010 WR_WAIT on Master_Done: Nack -> BACKOFF; soft-reset command -> IDLE; else -> MEAS_WAIT.
REQ-011 MEAS_WAIT SHALL count MEAS_WAIT_CYCLES then enter RD_START.
REQ-012 RD_COLLECT SHALL store Rx_Byte at index 0..5 per Rx_Valid; Rx_Valid beyond 6 bytes is dropped; Master_Done with Nack, or with fewer than 6 bytes -> BACKOFF; Master_Done after 6 bytes -> CHECK.
REQ-013 CHECK SHALL compute CRC-8 (poly 0x31, init 0xFF, no reflection, no final XOR) over bytes 0-1 vs byte 2 and bytes 3-4 vs byte 5.
REQ-014 On both CRCs matching, outputs SHALL latch {b0,b1} and {b3,b4}, pulse Meas_Valid one cycle, clear the retry count, and return to IDLE within 3 cycles of entering CHECK.
REQ-015 BACKOFF SHALL wait MEAS_WAIT_CYCLES, increment the retry count, and re-enter WR_START; once the count equals MAX_RETRY, it SHALL instead set the matching sticky error and go to IDLE.
REQ-016 A successful measurement SHALL clear both sticky errors.
REQ-017 Temperature_Output and Humidity_Output SHALL hold their values through failed measurements.

Reset
REQ-018 rst_n low SHALL force IDLE immediately, including mid-transaction.
REQ-019 Reset values: all outputs 0 except Peripheral_Address=0x44 and Command_Data_Frames=0xFD.
REQ-020 Reset values: counters and byte index 0; period counter loaded to PERIOD_CYCLES-1.

Structure
REQ-021 Shared package SHALL hold the state enum, SHT40 address 0x44, the four command codes, and the CRC polynomial/init constants.
REQ-022 CRC SHALL be a combinational sub-module sht40_crc8 (16-bit in, 8-bit out), instantiated twice.

Verification
REQ-023 Single_Shot, Cmd_Sel=00, bytes 66 66 93 66 66 93 -> write 0xFD, read after MEAS_WAIT_CYCLES, Temperature_Output=Humidity_Output=0x6666, one Meas_Valid.
REQ-024 sht40_crc8 input 0xBEEF -> output 0x92.
REQ-025 Byte 2 corrupted on every read, MAX_RETRY=3 -> 4 reads, CRC_Error_Out=1, outputs unchanged, IDLE.
REQ-026 Master_Nack on the first write, then good data -> one BACKOFF then Meas_Valid; Nack_Error_Out stays 0.
REQ-027 Enable=1, PERIOD_CYCLES=200, MEAS_WAIT_CYCLES=20 -> Processor_Ready write pulses spaced 200 cycles; Cmd_Sel=11 -> write only, no read.
REQ-028 rst_n low during RD_COLLECT -> IDLE and reset values next cycle; the next Single_Shot runs a normal measurement.
